// File: rtl/if_pc_gen_pkg.sv
// Shared types for the fetch-stage PC generator and its optional BTB.
// Fields in btb_entry_t are sized for the widest supported PC (64 bits); narrower configurations leave the upper bits constant.
package if_pc_gen_pkg;

  localparam int unsigned BTB_FIELD_W = 64;

  typedef enum logic [2:0] {
    PC_SEL_HOLD,
    PC_SEL_SEQ,
    PC_SEL_PRED,
    PC_SEL_JUMP,
    PC_SEL_BRANCH
  } pc_sel_e;

  typedef enum logic {
    PC_BOOT,
    PC_FETCH
  } pc_fsm_e;

  typedef struct packed {
    logic                   valid;
    logic [BTB_FIELD_W-1:0] tag;
    logic [BTB_FIELD_W-1:0] target;
  } btb_entry_t;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/if_btb.sv
// Direct-mapped branch target buffer: combinational lookup, write on posedge.
// Built only when IF_BTB_EN is defined.
module if_btb
  import if_pc_gen_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BTB_DEPTH = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [XLEN-1:0] i_lookup_pc,
  output logic            o_hit,
  output logic [XLEN-1:0] o_target,
  input  logic            i_wr_en,
  input  logic [XLEN-1:0] i_wr_pc,
  input  logic            i_wr_taken,
  input  logic [XLEN-1:0] i_wr_target
);

  localparam int IDX_W = $clog2(BTB_DEPTH);

  btb_entry_t       r_mem [BTB_DEPTH];
  btb_entry_t       w_rd;
  btb_entry_t       w_wr;
  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_wr_idx;

  assign w_rd_idx = i_lookup_pc[IDX_W+1:2];
  assign w_wr_idx = i_wr_pc[IDX_W+1:2];
  assign w_rd     = r_mem[w_rd_idx];
  assign o_hit    = w_rd.valid && (w_rd.tag == BTB_FIELD_W'(i_lookup_pc >> (IDX_W + 2)));
  assign o_target = XLEN'(w_rd.target);

  always_comb begin
    w_wr        = '0;
    w_wr.valid  = i_wr_taken;
    w_wr.tag    = BTB_FIELD_W'(i_wr_pc >> (IDX_W + 2));
    w_wr.target = BTB_FIELD_W'(i_wr_target);
  end

  // A same-cycle lookup of the written index still sees the old entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_mem[w_wr_idx] <= w_wr;
    end
  end

endmodule

// File: rtl/if_pc_gen.sv
// Fetch-stage PC generator: boot FSM, next-PC priority mux, req/gnt fetch handshake.
// Define IF_BTB_EN to add BTB-based taken-branch prediction.
module if_pc_gen
  import if_pc_gen_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              BTB_DEPTH    = 16
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            PC_Stall,
  input  logic            ID_Jump,
  input  logic [XLEN-1:0] ID_PC_dest,
  input  logic            EX_PC_Branch,
  input  logic [XLEN-1:0] EX_PC_Branch_dest,
  input  logic            EX_BTB_Update,
  input  logic [XLEN-1:0] EX_BTB_PC,
  input  logic            EX_BTB_Taken,
  input  logic [XLEN-1:0] EX_BTB_Target,
  input  logic            IF_Gnt,
  output logic            IF_Req,
  output logic [XLEN-1:0] PC_Out,
  output logic            PC_Valid,
  output logic            PC_Pred_Taken,
  output logic            PC_Misalign
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  pc_fsm_e         r_state;
  pc_fsm_e         w_state_nxt;
  pc_sel_e         w_sel;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic            r_pred;
  logic            w_pred_nxt;
  logic            r_mis;
  logic            w_mis_nxt;
  logic            w_btb_hit;
  logic [XLEN-1:0] w_btb_target;

`ifdef IF_BTB_EN
  if_btb #(
    .XLEN      (XLEN),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_btb (
    .i_clk       (Clk),
    .i_rst_n     (Reset_n),
    .i_lookup_pc (r_pc),
    .o_hit       (w_btb_hit),
    .o_target    (w_btb_target),
    .i_wr_en     (EX_BTB_Update),
    .i_wr_pc     (EX_BTB_PC),
    .i_wr_taken  (EX_BTB_Taken),
    .i_wr_target (EX_BTB_Target)
  );
`else
  logic w_unused_btb;
  assign w_btb_hit    = 1'b0;
  assign w_btb_target = '0;
  assign w_unused_btb = &{1'b0, EX_BTB_Update, EX_BTB_PC, EX_BTB_Taken, EX_BTB_Target};
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= PC_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    IF_Req      = 1'b0;
    PC_Valid    = 1'b0;
    case (r_state)
      PC_BOOT:  w_state_nxt = PC_FETCH;
      PC_FETCH: begin
        IF_Req   = 1'b1;
        PC_Valid = 1'b1;
      end
      default:  w_state_nxt = PC_BOOT;
    endcase
  end

  // Redirects (flushes) win over stall and a missing grant; nothing moves during boot.
  always_comb begin
    w_sel = PC_SEL_HOLD;
    if (r_state == PC_FETCH) begin
      if (EX_PC_Branch)              w_sel = PC_SEL_BRANCH;
      else if (ID_Jump)              w_sel = PC_SEL_JUMP;
      else if (PC_Stall || !IF_Gnt)  w_sel = PC_SEL_HOLD;
      else if (w_btb_hit)            w_sel = PC_SEL_PRED;
      else                           w_sel = PC_SEL_SEQ;
    end
  end

  always_comb begin
    w_pc_nxt   = r_pc;
    w_pred_nxt = r_pred;
    w_mis_nxt  = 1'b0;
    case (w_sel)
      PC_SEL_BRANCH: begin
        w_pc_nxt   = EX_PC_Branch_dest & ALIGN_MASK;
        w_pred_nxt = 1'b0;
        w_mis_nxt  = is_misaligned(EX_PC_Branch_dest[1:0]);
      end
      PC_SEL_JUMP: begin
        w_pc_nxt   = ID_PC_dest & ALIGN_MASK;
        w_pred_nxt = 1'b0;
        w_mis_nxt  = is_misaligned(ID_PC_dest[1:0]);
      end
      PC_SEL_PRED: begin
        w_pc_nxt   = w_btb_target & ALIGN_MASK;
        w_pred_nxt = 1'b1;
      end
      PC_SEL_SEQ: begin
        w_pc_nxt   = r_pc + XLEN'(4);
        w_pred_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pc   <= RESET_VECTOR;
      r_pred <= 1'b0;
      r_mis  <= 1'b0;
    end else begin
      r_pc   <= w_pc_nxt;
      r_pred <= w_pred_nxt;
      r_mis  <= w_mis_nxt;
    end
  end

  assign PC_Out        = r_pc;
  assign PC_Pred_Taken = r_pred;
  assign PC_Misalign   = r_mis;

endmodule

// File: tb/tb_if_pc_gen.sv
// Scoreboard bench for if_pc_gen: directed vectors push expected PC/flags, a monitor pops and compares each cycle.
// BTB scenarios adapt their expectations when IF_BTB_EN is defined.
module tb_if_pc_gen;
  import if_pc_gen_pkg::*;

  localparam int XLEN = 32;
`ifdef IF_BTB_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic            Clk = 1'b0;
  logic            Reset_n;
  logic            PC_Stall;
  logic            ID_Jump;
  logic [XLEN-1:0] ID_PC_dest;
  logic            EX_PC_Branch;
  logic [XLEN-1:0] EX_PC_Branch_dest;
  logic            EX_BTB_Update;
  logic [XLEN-1:0] EX_BTB_PC;
  logic            EX_BTB_Taken;
  logic [XLEN-1:0] EX_BTB_Target;
  logic            IF_Gnt;
  logic            IF_Req;
  logic [XLEN-1:0] PC_Out;
  logic            PC_Valid;
  logic            PC_Pred_Taken;
  logic            PC_Misalign;

  typedef struct {
    string           name;
    logic [XLEN-1:0] pc;
    logic            req;
    logic            valid;
    logic            pred;
    logic            mis;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  if_pc_gen #(
    .XLEN         (XLEN),
    .RESET_VECTOR (32'h0),
    .BTB_DEPTH    (16)
  ) dut (
    .Clk               (Clk),
    .Reset_n           (Reset_n),
    .PC_Stall          (PC_Stall),
    .ID_Jump           (ID_Jump),
    .ID_PC_dest        (ID_PC_dest),
    .EX_PC_Branch      (EX_PC_Branch),
    .EX_PC_Branch_dest (EX_PC_Branch_dest),
    .EX_BTB_Update     (EX_BTB_Update),
    .EX_BTB_PC         (EX_BTB_PC),
    .EX_BTB_Taken      (EX_BTB_Taken),
    .EX_BTB_Target     (EX_BTB_Target),
    .IF_Gnt            (IF_Gnt),
    .IF_Req            (IF_Req),
    .PC_Out            (PC_Out),
    .PC_Valid          (PC_Valid),
    .PC_Pred_Taken     (PC_Pred_Taken),
    .PC_Misalign       (PC_Misalign)
  );

  always #5 Clk = ~Clk;

  function automatic void checkOutput(input exp_t e);
    checks++;
    if (PC_Out !== e.pc || IF_Req !== e.req || PC_Valid !== e.valid ||
        PC_Pred_Taken !== e.pred || PC_Misalign !== e.mis) begin
      errors++;
      $display("[TB] FAIL %s: got pc=%h req=%b valid=%b pred=%b mis=%b, want pc=%h req=%b valid=%b pred=%b mis=%b",
               e.name, PC_Out, IF_Req, PC_Valid, PC_Pred_Taken, PC_Misalign,
               e.pc, e.req, e.valid, e.pred, e.mis);
    end
  endfunction

  task automatic checkReset(input string name);
    exp_t r;
    r.name  = name;
    r.pc    = 32'h0;
    r.req   = 1'b0;
    r.valid = 1'b0;
    r.pred  = 1'b0;
    r.mis   = 1'b0;
    checkOutput(r);
  endtask

  // Called at a negedge: drive one cycle of inputs, queue the state expected after the next posedge.
  task automatic applyStimulus(input string name, input logic stall, input logic gnt,
                               input logic jump, input logic [XLEN-1:0] jd,
                               input logic br, input logic [XLEN-1:0] bd,
                               input logic [XLEN-1:0] ePc, input logic ePred, input logic eMis);
    exp_t e;
    PC_Stall          = stall;
    IF_Gnt            = gnt;
    ID_Jump           = jump;
    ID_PC_dest        = jd;
    EX_PC_Branch      = br;
    EX_PC_Branch_dest = bd;
    e.name  = name;
    e.pc    = ePc;
    e.req   = 1'b1;
    e.valid = 1'b1;
    e.pred  = ePred;
    e.mis   = eMis;
    expQ.push_back(e);
    @(posedge Clk);
    @(negedge Clk);
    EX_BTB_Update = 1'b0;
  endtask

  task automatic stepSeq(input string name, input logic [XLEN-1:0] ePc, input logic ePred = 1'b0);
    applyStimulus(name, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0, ePc, ePred, 1'b0);
  endtask

  task automatic btbWrite(input logic [XLEN-1:0] pc, input logic taken, input logic [XLEN-1:0] tgt);
    EX_BTB_Update = 1'b1;
    EX_BTB_PC     = pc;
    EX_BTB_Taken  = taken;
    EX_BTB_Target = tgt;
  endtask

  initial begin
    forever begin
      @(posedge Clk);
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL timeout: got still running, want finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    Reset_n           = 1'b0;
    PC_Stall          = 1'b0;
    ID_Jump           = 1'b0;
    ID_PC_dest        = '0;
    EX_PC_Branch      = 1'b0;
    EX_PC_Branch_dest = '0;
    EX_BTB_Update     = 1'b0;
    EX_BTB_PC         = '0;
    EX_BTB_Taken      = 1'b0;
    EX_BTB_Target     = '0;
    IF_Gnt            = 1'b1;
    repeat (2) @(negedge Clk);
    #2;
    checkReset("reset");
    @(negedge Clk);
    Reset_n = 1'b1;

    applyStimulus("boot", 1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 32'h0, 1'b0, 1'b0);
    stepSeq("seq4", 32'h4);
    stepSeq("seq8", 32'h8);
    stepSeq("seqC", 32'hC);
    stepSeq("seq10", 32'h10);
    for (int i = 0; i < 3; i++)
      applyStimulus("noGnt", 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 32'h10, 1'b0, 1'b0);
    stepSeq("granted", 32'h14);
    applyStimulus("stallJump", 1'b1, 1'b1, 1'b1, 32'h100, 1'b0, '0, 32'h100, 1'b0, 1'b0);
    stepSeq("seq104", 32'h104);
    applyStimulus("branchBeatsJump", 1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 32'h300, 32'h300, 1'b0, 1'b0);
    stepSeq("seq304", 32'h304);
    applyStimulus("misBranch", 1'b0, 1'b1, 1'b0, '0, 1'b1, 32'h402, 32'h400, 1'b0, 1'b1);
    stepSeq("misCleared", 32'h404);
    applyStimulus("toTop", 1'b0, 1'b1, 1'b0, '0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 1'b0);
    stepSeq("wrap", 32'h0);
    stepSeq("afterWrap", 32'h4);
    applyStimulus("stallHold", 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 32'h4, 1'b0, 1'b0);
    applyStimulus("branchNoGnt", 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h50, 32'h50, 1'b0, 1'b0);
    applyStimulus("misJump", 1'b0, 1'b1, 1'b1, 32'h61, 1'b0, '0, 32'h60, 1'b0, 1'b1);
    applyStimulus("misPulseEnd", 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 32'h60, 1'b0, 1'b0);

    btbWrite(32'h20, 1'b1, 32'h80);
    applyStimulus("install", 1'b0, 1'b1, 1'b0, '0, 1'b1, 32'h10, 32'h10, 1'b0, 1'b0);
    stepSeq("walk14", 32'h14);
    stepSeq("walk18", 32'h18);
    stepSeq("walk1C", 32'h1C);
    stepSeq("walk20", 32'h20);
    stepSeq("visit20", BTB ? 32'h80 : 32'h24, BTB);
    applyStimulus("predHold", 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, BTB ? 32'h80 : 32'h24, BTB, 1'b0);
    btbWrite(32'h20, 1'b0, 32'h80);
    applyStimulus("invalidate", 1'b0, 1'b1, 1'b0, '0, 1'b1, 32'h1C, 32'h1C, 1'b0, 1'b0);
    stepSeq("reach20", 32'h20);
    stepSeq("afterInval", 32'h24);
    btbWrite(32'h20, 1'b1, 32'h80);
    applyStimulus("reinstall", 1'b0, 1'b1, 1'b1, 32'h80, 1'b0, '0, 32'h80, 1'b0, 1'b0);

    #2;
    Reset_n = 1'b0;
    #1;
    checkReset("asyncReset");
    @(negedge Clk);
    checkReset("resetHeld");
    Reset_n = 1'b1;
    applyStimulus("reboot", 1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 32'h0, 1'b0, 1'b0);
    applyStimulus("revisit", 1'b0, 1'b1, 1'b0, '0, 1'b1, 32'h20, 32'h20, 1'b0, 1'b0);
    stepSeq("btbCleared", 32'h24);

    repeat (2) @(posedge Clk);
    #2;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending, want 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
